sr_cmd_gen: RTL and testbench

Upstream command stage for the NAND-style SR latch, whose set/reset inputs are active-low. Takes two raw asynchronous push-button inputs and synchronizes and debounces them. Converts each debounced press into a fixed-width active-low pulse on set_n or reset_n. Guarantees that set_n and reset_n are never low together, because that is the forbidden input state for the latch.

---
 rtl/sr_cmd_gen.sv | 150 +++++++++++++++
 tb/tb_sr_cmd_gen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: button synchronizer, debouncer and pulse sequencer
// that drives the active-low set/reset inputs of a NAND SR latch.
module sr_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic reset_btn,
  output logic set_n,
  output logic reset_n,
  output logic busy,
  output logic conflict
);

  localparam logic [CNT_W-1:0] LP_DB_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_PL_LAST =
    CNT_W'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SET_P,
    RST_P,
    GAP
  } state_t;

  // channel 0 = set, channel 1 = reset
  logic [1:0]       w_btn;
  logic [1:0]       r_s1;
  logic [1:0]       r_s2;
  logic [1:0]       r_db;
  logic [1:0]       r_db_d;
  logic [1:0]       r_pend;
  logic [CNT_W-1:0] r_db_cnt [2];
  logic [1:0]       w_rise;
  logic [1:0]       w_req;

  state_t           r_state;
  logic [CNT_W-1:0] r_pl_cnt;
  logic             r_set_n;
  logic             r_rst_n;
  logic             r_busy;
  logic             r_conflict;

  assign w_btn  = {reset_btn, set_btn};
  assign w_rise = r_db & ~r_db_d;
  assign w_req  = r_pend | w_rise;

  // two-flop synchronizer for both raw buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_btn;
      r_s2 <= r_s1;
    end
  end

  // debounce: level follows synced value after a stable run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db   <= '0;
      r_db_d <= '0;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      r_db_d <= r_db;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] != r_db[i]) begin
          if (r_db_cnt[i] == LP_DB_LAST) begin
            r_db[i]     <= r_s2[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  // pulse sequencer with pending flags and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pl_cnt   <= '0;
      r_set_n    <= 1'b1;
      r_rst_n    <= 1'b1;
      r_busy     <= 1'b0;
      r_pend     <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= &w_rise;
      r_pend     <= w_req;
      unique case (r_state)
        IDLE: begin
          if (w_req[1]) begin
            r_state   <= RST_P;
            r_rst_n   <= 1'b0;
            r_busy    <= 1'b1;
            r_pl_cnt  <= '0;
            r_pend[1] <= 1'b0;
          end else if (w_req[0]) begin
            r_state   <= SET_P;
            r_set_n   <= 1'b0;
            r_busy    <= 1'b1;
            r_pl_cnt  <= '0;
            r_pend[0] <= 1'b0;
          end
        end
        SET_P: begin
          if (r_pl_cnt == LP_PL_LAST) begin
            r_state <= GAP;
            r_set_n <= 1'b1;
          end else begin
            r_pl_cnt <= r_pl_cnt + 1'b1;
          end
        end
        RST_P: begin
          if (r_pl_cnt == LP_PL_LAST) begin
            r_state <= GAP;
            r_rst_n <= 1'b1;
          end else begin
            r_pl_cnt <= r_pl_cnt + 1'b1;
          end
        end
        GAP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_set_n <= 1'b1;
          r_rst_n <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign set_n    = r_set_n;
  assign reset_n  = r_rst_n;
  assign busy     = r_busy;
  assign conflict = r_conflict;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb_sr_cmd_gen: directed vector table plus hand sequences
// for the SR latch command generator.
module tb_sr_cmd_gen;

  logic clk;
  logic rst_n;
  logic set_btn;
  logic reset_btn;
  logic set_n;
  logic reset_n;
  logic busy;
  logic conflict;

  int n_vec;
  int n_err;
  logic found;

  typedef struct {
    logic sb;
    logic rb;
    logic e_set_n;
    logic e_rst_n;
    logic e_busy;
    logic e_conf;
  } vec_t;

  vec_t tbl[$];

  sr_cmd_gen #(
    .DEBOUNCE_CYCLES(4),
    .PULSE_CYCLES(2),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .set_btn(set_btn),
    .reset_btn(reset_btn),
    .set_n(set_n),
    .reset_n(reset_n),
    .busy(busy),
    .conflict(conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // the latch must never see both inputs low
  always @(negedge clk) begin
    if (rst_n === 1'b1 && set_n === 1'b0 && reset_n === 1'b0) begin
      n_err++;
      $display("FAIL forbidden: set_n=0 reset_n=0 at %0t", $time);
    end
  end

  function automatic void add(logic sb, logic rb, logic es,
                              logic er, logic eb, logic ec);
    vec_t v;
    v.sb = sb; v.rb = rb;
    v.e_set_n = es; v.e_rst_n = er;
    v.e_busy = eb; v.e_conf = ec;
    tbl.push_back(v);
  endfunction

  task automatic chk(string nm, int idx, logic act, logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %b expected %b", nm, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(string nm, int idx);
    chk({nm, ".set_n"}, idx, set_n, 1'b1);
    chk({nm, ".reset_n"}, idx, reset_n, 1'b1);
    chk({nm, ".busy"}, idx, busy, 1'b0);
    chk({nm, ".conflict"}, idx, conflict, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    set_btn = 1'b0;
    reset_btn = 1'b0;

    // clean set press: low after edges 7,8; busy 7..9
    for (int i = 0; i < 12; i++)
      add(1, 0, !(i == 6 || i == 7), 1, (i >= 6 && i <= 8), 0);
    for (int i = 0; i < 8; i++) add(0, 0, 1, 1, 0, 0);
    // bounce on reset: highs of 1,2,3 then final rise at 12
    add(0, 1, 1, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0);
    add(0, 1, 1, 1, 0, 0);
    add(0, 1, 1, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0);
    add(0, 1, 1, 1, 0, 0);
    add(0, 1, 1, 1, 0, 0);
    add(0, 1, 1, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 12; i++)
      add(0, 1, 1, !(i == 6 || i == 7), (i >= 6 && i <= 8), 0);
    for (int i = 0; i < 8; i++) add(0, 0, 1, 1, 0, 0);
    // simultaneous press: reset pulse, gap, idle, set pulse
    for (int i = 0; i < 14; i++)
      add(1, 1, !(i == 10 || i == 11), !(i == 6 || i == 7),
          (i >= 6 && i <= 8) || (i >= 10 && i <= 12), (i == 6));
    for (int i = 0; i < 8; i++) add(0, 0, 1, 1, 0, 0);

    // reset held while buttons toggle
    for (int i = 0; i < 6; i++) begin
      set_btn = i[0];
      reset_btn = i[1];
      step();
      chk_idle("in_reset", i);
    end
    set_btn = 1'b0;
    reset_btn = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_idle("post_reset", i);
    end

    // vector table
    foreach (tbl[i]) begin
      set_btn = tbl[i].sb;
      reset_btn = tbl[i].rb;
      step();
      chk("tbl.set_n", i, set_n, tbl[i].e_set_n);
      chk("tbl.reset_n", i, reset_n, tbl[i].e_rst_n);
      chk("tbl.busy", i, busy, tbl[i].e_busy);
      chk("tbl.conflict", i, conflict, tbl[i].e_conf);
    end

    // reset request debounced while set pulse is active
    for (int i = 0; i < 16; i++) begin
      set_btn = 1'b1;
      reset_btn = (i >= 1);
      step();
      chk("busy_req.set_n", i, set_n, !(i == 6 || i == 7));
      chk("busy_req.reset_n", i, reset_n, !(i == 10 || i == 11));
      chk("busy_req.busy", i, busy,
          (i >= 6 && i <= 8) || (i >= 10 && i <= 12));
    end
    set_btn = 1'b0;
    reset_btn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_idle("busy_rel", i);
    end

    // async reset during the first cycle of a set pulse
    set_btn = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (set_n === 1'b0) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL mid_rst.wait: got no set pulse expected one");
    end
    #2;
    rst_n = 1'b0;
    set_btn = 1'b0;
    #1;
    chk("mid_rst.set_n", 0, set_n, 1'b1);
    chk("mid_rst.reset_n", 0, reset_n, 1'b1);
    chk("mid_rst.busy", 0, busy, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      chk_idle("mid_rst_after", i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
